// File: rtl/accum_buffer.sv
// accum_buffer
// -----------------------------------------------------------------------------
// Accumulator stage behind the systolic array. Incoming partial-sum rows are
// either written (first K-slice) or added (later K-slices) into a DEPTH-row
// register bank. When the tile is marked final, the finished tile is drained
// row by row through a valid/ready stream.
//
// Optional feature macro: ACCUM_SATURATE_EN
//   defined   -> accumulate clamps each lane to the signed ACC_W range
//   undefined -> accumulate wraps modulo 2^ACC_W
//   ovf is set on signed overflow in both builds.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   rows                rows per tile, sampled at tile start (0 -> 1, >DEPTH -> DEPTH)
//   in_valid/in_ready   partial-sum row handshake (in_ready low while draining)
//   in_data             N signed lanes of IN_W, lane k at [k*IN_W +: IN_W]
//   store_buffered      tile is final: drain after its last row
//   overwrite_buffered  tile is first K-slice: write instead of add
//   out_valid/out_ready drain row handshake
//   out_data            N lanes of ACC_W, same packing as in_data
//   out_last            high with the final drain row of the tile
//   tile_done           one-cycle pulse after a tile's last input row
//   ovf                 sticky signed-overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module accum_buffer #(
  parameter int N     = 4,
  parameter int IN_W  = 32,
  parameter int ACC_W = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH):0]   rows,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*IN_W-1:0]        in_data,
  input  logic                     store_buffered,
  input  logic                     overwrite_buffered,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*ACC_W-1:0]       out_data,
  output logic                     out_last,
  output logic                     tile_done,
  output logic                     ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = $clog2(DEPTH) + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Tile registers, latched on the first beat of each tile.
  logic          ow_q;
  logic          st_q;
  logic [RW-1:0] rows_eff_q;

  logic [ACC_W-1:0] bank [DEPTH][N];

  logic          beat;
  logic          tile_start;
  logic          last_beat;
  logic          ow_cur;
  logic          st_cur;
  logic [RW-1:0] rows_clamped;
  logic [RW-1:0] rows_cur;

  logic [ACC_W-1:0] x_ext   [N];
  logic [ACC_W:0]   sum     [N];
  logic [ACC_W-1:0] new_val [N];
  logic [N-1:0]     add_ovf;
  logic [N-1:0]     lane_ovf;

  // ---------------------------------------------------------------------------
  // Tile control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    rows_clamped = rows;
    if (rows == '0) begin
      rows_clamped = RW'(1);
    end else if (rows > RW'(DEPTH)) begin
      rows_clamped = RW'(DEPTH);
    end
  end

  assign beat       = in_valid && in_ready;
  assign tile_start = (wr_ptr == '0);

  // On the tile's first beat the live inputs apply directly; afterwards only
  // the latched copies matter, so mid-tile changes upstream are ignored.
  assign ow_cur   = tile_start ? overwrite_buffered : ow_q;
  assign st_cur   = tile_start ? store_buffered     : st_q;
  assign rows_cur = tile_start ? rows_clamped       : rows_eff_q;

  assign last_beat = beat && (RW'(wr_ptr) == rows_cur - RW'(1));

  // ---------------------------------------------------------------------------
  // Lane arithmetic
  // ---------------------------------------------------------------------------
  always_comb begin
    add_ovf  = '0;
    lane_ovf = '0;
    for (int k = 0; k < N; k++) begin
      x_ext[k] = ACC_W'($signed(in_data[k*IN_W +: IN_W]));
      // One extra bit of headroom: overflow shows up as the top two bits
      // disagreeing.
      sum[k] = {bank[wr_ptr][k][ACC_W-1], bank[wr_ptr][k]}
             + {x_ext[k][ACC_W-1], x_ext[k]};
      add_ovf[k] = sum[k][ACC_W] ^ sum[k][ACC_W-1];
`ifdef ACCUM_SATURATE_EN
      if (add_ovf[k]) begin
        // sum[ACC_W] is the true sign: negative overflow clamps to the minimum.
        new_val[k] = sum[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        new_val[k] = sum[k][ACC_W-1:0];
      end
`else
      new_val[k] = sum[k][ACC_W-1:0];
`endif
      if (ow_cur) begin
        new_val[k] = x_ext[k];
      end
      lane_ovf[k] = add_ovf[k] && !ow_cur;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat && st_cur) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && out_last) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign out_last = (state_q == DRAIN) && (RW'(rd_ptr) == rows_eff_q - RW'(1));

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      out_data[k*ACC_W +: ACC_W] = bank[rd_ptr][k];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ow_q       <= 1'b0;
      st_q       <= 1'b0;
      rows_eff_q <= '0;
      tile_done  <= 1'b0;
      ovf        <= 1'b0;
      // NOTE: the bank is reset on purpose: an accumulate-mode tile after
      // reset must start from zero, so this memory cannot be left unreset.
      for (int r = 0; r < DEPTH; r++) begin
        for (int k = 0; k < N; k++) begin
          bank[r][k] <= '0;
        end
      end
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      tile_done <= last_beat;

      if (beat) begin
        if (tile_start) begin
          ow_q       <= overwrite_buffered;
          st_q       <= store_buffered;
          rows_eff_q <= rows_clamped;
        end
        for (int k = 0; k < N; k++) begin
          bank[wr_ptr][k] <= new_val[k];
        end
        ovf    <= ovf | (|lane_ovf);
        wr_ptr <= last_beat ? '0 : wr_ptr + PTR_W'(1);
      end

      if (out_valid && out_ready) begin
        rd_ptr <= out_last ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_accum_buffer.sv
// Directed testbench for accum_buffer: default instance (N=4, 32-bit lanes)
// plus an 8-bit instance for the overflow case.
module tb_accum_buffer;

  logic clk;
  logic rst;

  // Default instance
  logic [4:0]   rows;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         store;
  logic         overwrite;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         tile_done;
  logic         ovf;

  // 8-bit instance
  logic [4:0]  rows8;
  logic        in_valid8;
  logic        in_ready8;
  logic [31:0] in_data8;
  logic        store8;
  logic        overwrite8;
  logic        out_valid8;
  logic        out_ready8;
  logic [31:0] out_data8;
  logic        out_last8;
  logic        tile_done8;
  logic        ovf8;

  int checks;
  int failures;

  accum_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .rows               (rows),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .store_buffered     (store),
    .overwrite_buffered (overwrite),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .tile_done          (tile_done),
    .ovf                (ovf)
  );

  accum_buffer #(.N(4), .IN_W(8), .ACC_W(8), .DEPTH(16)) dut8 (
    .clk                (clk),
    .rst                (rst),
    .rows               (rows8),
    .in_valid           (in_valid8),
    .in_ready           (in_ready8),
    .in_data            (in_data8),
    .store_buffered     (store8),
    .overwrite_buffered (overwrite8),
    .out_valid          (out_valid8),
    .out_ready          (out_ready8),
    .out_data           (out_data8),
    .out_last           (out_last8),
    .tile_done          (tile_done8),
    .ovf                (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pack(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // One beat on the default instance; returns 1 ns after the accepting edge
  // with in_valid still high.
  task automatic drive_beat(input logic [127:0] d, input logic ow, input logic st,
                            input logic [4:0] r);
    in_valid  = 1'b1;
    in_data   = d;
    overwrite = ow;
    store     = st;
    rows      = r;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (tile_done !== 1'b0 || out_last !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b exp=000", tile_done, out_last, ovf); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_drain;
    for (int i = 0; i < 4; i++) begin
      drive_beat(pack(i + 1, 10 * (i + 1), -(i + 1), 0), 1'b1, 1'b1, 5'd4);
      checks++;
      if (tile_done !== 1'(i == 3)) begin
        failures++; $display("FAIL t1_tile_done beat%0d got=%b exp=%b", i, tile_done, i == 3);
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL t1_enter_drain got=%b%b exp=10", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== pack(i + 1, 10 * (i + 1), -(i + 1), 0)) begin
        failures++; $display("FAIL t1_row%0d got=%h exp=%h", i, out_data, pack(i + 1, 10 * (i + 1), -(i + 1), 0));
      end
      checks++;
      if (out_last !== 1'(i == 3)) begin
        failures++; $display("FAIL t1_last row%0d got=%b exp=%b", i, out_last, i == 3);
      end
      if (i == 1) begin
        checks++; if (tile_done !== 1'b0) begin failures++; $display("FAIL t1_pulse_width got=%b exp=0", tile_done); end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL t1_exit_drain got=%b%b exp=01", out_valid, in_ready); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL t1_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_accumulate;
    drive_beat(pack(5, 5, 5, 5), 1'b1, 1'b0, 5'd2);
    drive_beat(pack(5, 5, 5, 5), 1'b1, 1'b0, 5'd2);
    checks++; if (tile_done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL t2_tileA_end got=%b%b%b exp=101", tile_done, out_valid, in_ready); end
    drive_beat(pack(-2, -2, -2, -2), 1'b0, 1'b1, 5'd2);
    // Mid-tile flag/rows changes must be ignored.
    drive_beat(pack(-2, -2, -2, -2), 1'b1, 1'b0, 5'd1);
    in_valid = 1'b0;
    checks++; if (tile_done !== 1'b1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL t2_tileB_end got=%b%b exp=11", tile_done, out_valid); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_data !== pack(3, 3, 3, 3) || out_last !== 1'(i == 1)) begin
        failures++; $display("FAIL t2_row%0d got=%h last=%b exp=%h last=%b", i, out_data, out_last, pack(3, 3, 3, 3), i == 1);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL t2_drain_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_row;
`ifdef ACCUM_SATURATE_EN
    exp_row = pack8(127, 0, 0, 0);
`else
    exp_row = pack8(-56, 0, 0, 0);
`endif
    in_valid8 = 1'b1; in_data8 = pack8(100, 0, 0, 0); overwrite8 = 1'b1; store8 = 1'b0; rows8 = 5'd1;
    @(posedge clk); #1;
    checks++; if (ovf8 !== 1'b0 || tile_done8 !== 1'b1) begin
      failures++; $display("FAIL t3_first got=ovf%b done%b exp=ovf0 done1", ovf8, tile_done8); end
    overwrite8 = 1'b0; store8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++; if (ovf8 !== 1'b1) begin failures++; $display("FAIL t3_ovf got=%b exp=1", ovf8); end
    checks++; if (out_valid8 !== 1'b1 || out_data8 !== exp_row || out_last8 !== 1'b1) begin
      failures++; $display("FAIL t3_row got=%h v%b l%b exp=%h v1 l1", out_data8, out_valid8, out_last8, exp_row); end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    checks++; if (out_valid8 !== 1'b0 || ovf8 !== 1'b1) begin
      failures++; $display("FAIL t3_after got=v%b ovf%b exp=v0 ovf1", out_valid8, ovf8); end
  endtask

  task automatic test_stall_drain;
    logic [127:0] exp_rows [3];
    bit           pat [12] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int           idx;
    int           c;
    for (int i = 0; i < 3; i++) begin
      exp_rows[i] = pack(7 + i, 70 + i, 0, -7 - i);
      drive_beat(exp_rows[i], 1'b1, 1'b1, 5'd3);
    end
    // Hold junk on the input during the drain; it must not be taken.
    in_data = pack(99, 99, 99, 99);
    idx = 0;
    c   = 0;
    while (idx < 3 && c < 12) begin
      out_ready = pat[c];
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_rows[idx] || out_last !== 1'(idx == 2)) begin
        failures++; $display("FAIL t4_cycle%0d got=%h v%b r%b l%b exp=%h row%0d", c, out_data, out_valid, in_ready, out_last, exp_rows[idx], idx);
      end
      if (out_ready && idx == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      if (pat[c]) idx++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (idx != 3) begin failures++; $display("FAIL t4_timeout rows_seen=%0d exp=3", idx); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL t4_exit got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_flag_flip_and_rows0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(pack(i, i, i, i), 1'b1, 1'(i >= 1), 5'd3);
    end
    in_valid = 1'b0;
    checks++; if (tile_done !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL t5_flip got=done%b v%b exp=done1 v0", tile_done, out_valid); end
    drive_beat(pack(42, -42, 1, 0), 1'b1, 1'b1, 5'd0);
    in_valid = 1'b0;
    checks++; if (tile_done !== 1'b1 || out_valid !== 1'b1 || out_last !== 1'b1) begin
      failures++; $display("FAIL t5_rows0_ctrl got=done%b v%b l%b exp=111", tile_done, out_valid, out_last); end
    checks++; if (out_data !== pack(42, -42, 1, 0)) begin
      failures++; $display("FAIL t5_rows0_data got=%h exp=%h", out_data, pack(42, -42, 1, 0)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL t5_exit got=%b%b exp=01", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_drain;
    for (int i = 0; i < 3; i++) begin
      drive_beat(pack(11 + i, 11 + i, 11 + i, 11 + i), 1'b1, 1'b1, 5'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_data !== pack(12, 12, 12, 12)) begin
      failures++; $display("FAIL t6_row1 got=%h exp=%h", out_data, pack(12, 12, 12, 12)); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || tile_done !== 1'b0 || out_data !== '0) begin
      failures++; $display("FAIL t6_async got=v%b r%b d%b data=%h exp=v0 r1 d0 data=0", out_valid, in_ready, tile_done, out_data); end
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    drive_beat(pack(9, 9, 9, 9), 1'b0, 1'b1, 5'd1);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== pack(9, 9, 9, 9)) begin
      failures++; $display("FAIL t6_fresh got=v%b %h exp=v1 %h", out_valid, out_data, pack(9, 9, 9, 9)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || ovf !== 1'b0) begin
      failures++; $display("FAIL t6_end got=v%b ovf%b exp=v0 ovf0", out_valid, ovf); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    rows       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    store      = 1'b0;
    overwrite  = 1'b0;
    out_ready  = 1'b0;
    rows8      = '0;
    in_valid8  = 1'b0;
    in_data8   = '0;
    store8     = 1'b0;
    overwrite8 = 1'b0;
    out_ready8 = 1'b0;

    test_reset();
    test_store_drain();
    test_accumulate();
    test_overflow();
    test_stall_drain();
    test_flag_flip_and_rows0();
    test_reset_mid_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
